// File: rtl/amdc_dac_pkg.sv
// Shared types and frame layout for the AMDC SPI DAC sequencer.
package amdc_dac_pkg;

   // Sequencer state encodings, kept as plain constants for older tools.
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SCAN      = 3'd1;
   localparam logic [2:0] ST_SEND      = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_WAIT_TRIG = 3'd4;
   localparam logic [2:0] ST_LDAC      = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE      = ST_IDLE,
      S_SCAN      = ST_SCAN,
      S_SEND      = ST_SEND,
      S_WAIT_DONE = ST_WAIT_DONE,
      S_WAIT_TRIG = ST_WAIT_TRIG,
      S_LDAC      = ST_LDAC
   } state_t;

   // Frame layout: {cmd[23:20], ch[19:16], data left-aligned in [15:0]}.
   localparam logic [3:0] FRAME_CMD_WRITE = 4'b0000;
   localparam int         FRAME_BITS      = 24;
   localparam int         CMD_LSB         = 20;
   localparam int         CH_LSB          = 16;
   localparam int         DATA_FIELD_W    = 16;

   // Assemble a write frame; data_left already carries the code MSB-aligned.
   function automatic logic [FRAME_BITS-1:0] build_frame(
      input logic [3:0]              ch,
      input logic [DATA_FIELD_W-1:0] data_left
   );
      logic [FRAME_BITS-1:0] f;
      f                     = '0;
      f[CMD_LSB +: 4]       = FRAME_CMD_WRITE;
      f[CH_LSB +: 4]        = ch;
      f[0 +: DATA_FIELD_W]  = data_left;
      return f;
   endfunction

endpackage

// File: rtl/amdc_dac_rr_pick.sv
// Round-robin first-set finder: lowest dirty index at or after rr_ptr, wrapping.
module amdc_dac_rr_pick #(
   parameter int NUM_CH = 8
) (
   input  logic [NUM_CH-1:0]         dirty,
   input  logic [$clog2(NUM_CH)-1:0] rr_ptr,
   output logic [$clog2(NUM_CH)-1:0] idx,
   output logic                      found
);
   localparam int PTR_W = $clog2(NUM_CH);

   logic [NUM_CH-1:0] rotated;
   logic [PTR_W-1:0]  offset;

   // Rotate so bit 0 is the channel rr_ptr points at; NUM_CH is a power of two so the add wraps.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
         assign rotated[gi] = dirty[rr_ptr + PTR_W'(gi)];
      end
   endgenerate

   // Lowest set bit of the rotated vector is the distance from rr_ptr.
   always_comb begin
      offset = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (rotated[i]) offset = PTR_W'(i);
      end
   end

   assign found = |dirty;
   assign idx   = rr_ptr + offset;

endmodule

// File: rtl/amdc_dac_sequencer.sv
// Shadows per-channel DAC codes, serialises dirty channels round-robin into
// SPI frames, then strobes LDAC immediately or on the PWM carrier trigger.
module amdc_dac_sequencer
   import amdc_dac_pkg::*;
#(
   parameter int NUM_CH     = 8,
   parameter int DATA_W     = 12,
   parameter int FRAME_W    = 24,
   parameter int LDAC_PULSE = 4
) (
   input  logic                      ACLK,
   input  logic                      ARESETN,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [$clog2(NUM_CH)-1:0] wr_ch,
   input  logic [DATA_W-1:0]         wr_data,
   input  logic                      mode,
   input  logic                      trigger,
   output logic                      frame_valid,
   input  logic                      frame_ready,
   output logic [FRAME_W-1:0]        frame_data,
   input  logic                      frame_done,
   output logic                      ldac_n,
   output logic                      busy,
   output logic                      trig_late,
   input  logic                      clr_flags
);
   localparam int PTR_W = $clog2(NUM_CH);
   localparam int CNT_W = $clog2(LDAC_PULSE + 1);

   state_t               state_reg, state_next;
   logic [DATA_W-1:0]    shadow_reg [NUM_CH];
   logic [NUM_CH-1:0]    dirty_reg, dirty_next;
   logic [PTR_W-1:0]     rr_ptr_reg, rr_ptr_next;
   logic                 pend_trig_reg, pend_trig_next;
   logic                 sent_reg, sent_next;
   logic                 frame_valid_reg, frame_valid_next;
   logic [FRAME_W-1:0]   frame_data_reg, frame_data_next;
   logic [CNT_W-1:0]     ldac_cnt_reg, ldac_cnt_next;
   logic                 trig_late_reg, trig_late_next;
   logic                 ldac_n_reg;
   logic                 wr_ready_reg;

   logic                    wr_fire;
   logic                    any_dirty;
   logic                    trig_in_flight;
   logic [NUM_CH-1:0]       ch_hit;
   logic [PTR_W-1:0]        pick_idx;
   logic                    pick_found;
   logic [DATA_FIELD_W-1:0] pick_data_left;

   assign wr_fire        = wr_valid & wr_ready_reg;
   assign any_dirty      = |dirty_reg;
   // A trigger while a batch is still being shifted is late: remember it for LDAC.
   assign trig_in_flight = mode & trigger &
                           ((state_reg == S_SCAN) || (state_reg == S_SEND) ||
                            (state_reg == S_WAIT_DONE));
   assign pick_data_left = DATA_FIELD_W'(shadow_reg[pick_idx]) << (DATA_FIELD_W - DATA_W);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_hit
         assign ch_hit[gi] = wr_fire && (wr_ch == PTR_W'(gi));
      end
   endgenerate

   amdc_dac_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
      .dirty  (dirty_reg),
      .rr_ptr (rr_ptr_reg),
      .idx    (pick_idx),
      .found  (pick_found)
   );

   // Shadow registers take every accepted write, in any state.
   always_ff @(posedge ACLK) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (!ARESETN)       shadow_reg[i] <= '0;
         else if (ch_hit[i]) shadow_reg[i] <= wr_data;
      end
   end

   // Next-state logic for the batch scheduler and its flags.
   always_comb begin
      state_next       = state_reg;
      dirty_next       = dirty_reg;
      rr_ptr_next      = rr_ptr_reg;
      pend_trig_next   = pend_trig_reg | trig_in_flight;
      sent_next        = sent_reg;
      frame_valid_next = frame_valid_reg;
      frame_data_next  = frame_data_reg;
      ldac_cnt_next    = '0;
      trig_late_next   = trig_late_reg;

      case (state_reg)
         S_IDLE: begin
            if (any_dirty) state_next = S_SCAN;
         end
         S_SCAN: begin
            if (pick_found) begin
               frame_data_next       = FRAME_W'(build_frame(4'(pick_idx), pick_data_left));
               dirty_next[pick_idx]  = 1'b0;
               rr_ptr_next           = pick_idx + PTR_W'(1);
               frame_valid_next      = 1'b1;
               state_next            = S_SEND;
            end else begin
               state_next = S_IDLE;
            end
         end
         S_SEND: begin
            if (frame_ready) begin
               frame_valid_next = 1'b0;
               sent_next        = 1'b1;
               state_next       = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (frame_done) begin
               if (any_dirty)                            state_next = S_SCAN;
               else if (!mode)                           state_next = S_LDAC;
               else if (pend_trig_reg || trig_in_flight) state_next = S_LDAC;
               else                                      state_next = S_WAIT_TRIG;
            end
         end
         S_WAIT_TRIG: begin
            // New data outranks the trigger; that trigger is then held for the next LDAC.
            if (any_dirty) begin
               state_next = S_SCAN;
               if (mode && trigger) pend_trig_next = 1'b1;
            end else if (mode && trigger && sent_reg) begin
               state_next = S_LDAC;
            end
         end
         S_LDAC: begin
            if (ldac_cnt_reg == CNT_W'(LDAC_PULSE - 1)) begin
               pend_trig_next = 1'b0;
               sent_next      = 1'b0;
               state_next     = S_IDLE;
            end else begin
               ldac_cnt_next = ldac_cnt_reg + CNT_W'(1);
            end
         end
         default: state_next = S_IDLE;
      endcase

      // A write in the same cycle as the scan keeps the channel dirty.
      if (wr_fire) dirty_next[wr_ch] = 1'b1;

      if (clr_flags)           trig_late_next = 1'b0;
      else if (trig_in_flight) trig_late_next = 1'b1;
   end

   // State and output registers.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_reg       <= S_IDLE;
         dirty_reg       <= '0;
         rr_ptr_reg      <= '0;
         pend_trig_reg   <= 1'b0;
         sent_reg        <= 1'b0;
         frame_valid_reg <= 1'b0;
         frame_data_reg  <= '0;
         ldac_cnt_reg    <= '0;
         trig_late_reg   <= 1'b0;
         ldac_n_reg      <= 1'b1;
         wr_ready_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         dirty_reg       <= dirty_next;
         rr_ptr_reg      <= rr_ptr_next;
         pend_trig_reg   <= pend_trig_next;
         sent_reg        <= sent_next;
         frame_valid_reg <= frame_valid_next;
         frame_data_reg  <= frame_data_next;
         ldac_cnt_reg    <= ldac_cnt_next;
         trig_late_reg   <= trig_late_next;
         ldac_n_reg      <= (state_next != S_LDAC);
         wr_ready_reg    <= 1'b1;
      end
   end

   assign wr_ready    = wr_ready_reg;
   assign frame_valid = frame_valid_reg;
   assign frame_data  = frame_data_reg;
   assign ldac_n      = ldac_n_reg;
   assign busy        = (state_reg != S_IDLE);
   assign trig_late   = trig_late_reg;

endmodule

// File: tb/tb_amdc_dac_sequencer.sv
// Scenario bench for amdc_dac_sequencer with a frame scoreboard and SPI shifter model.
module tb_amdc_dac_sequencer;
   localparam int NUM_CH     = 8;
   localparam int DATA_W     = 12;
   localparam int FRAME_W    = 24;
   localparam int LDAC_PULSE = 4;
   localparam int DONE_DLY   = 10;

   logic               ACLK = 1'b0;
   logic               ARESETN = 1'b0;
   logic               wr_valid = 1'b0;
   logic               wr_ready;
   logic [2:0]         wr_ch = '0;
   logic [DATA_W-1:0]  wr_data = '0;
   logic               mode = 1'b0;
   logic               trigger = 1'b0;
   logic               frame_valid;
   logic               frame_ready = 1'b0;
   logic [FRAME_W-1:0] frame_data;
   logic               frame_done = 1'b0;
   logic               ldac_n;
   logic               busy;
   logic               trig_late;
   logic               clr_flags = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int hs_count = 0;
   int ldac_pulses = 0;
   int ldac_width = 0;
   int ldac_fall_cyc = -1;
   int done_cyc = -1;
   bit shifter_busy = 1'b0;
   logic ldac_prev = 1'b1;
   logic [FRAME_W-1:0] sb[$];
   logic [FRAME_W-1:0] sb_exp;

   amdc_dac_sequencer #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_W(FRAME_W), .LDAC_PULSE(LDAC_PULSE)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_data(wr_data),
      .mode(mode), .trigger(trigger),
      .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
      .frame_done(frame_done), .ldac_n(ldac_n), .busy(busy),
      .trig_late(trig_late), .clr_flags(clr_flags)
   );

   always #5 ACLK = ~ACLK;
   always @(posedge ACLK) cyc <= cyc + 1;

   // SPI shifter model: accepts frames, checks them against the scoreboard, pulses done later.
   initial begin : shifter
      forever begin
         @(negedge ACLK);
         #1;
         if (ARESETN === 1'b1 && frame_valid === 1'b1 && frame_ready === 1'b1) begin
            shifter_busy = 1'b1;
            hs_count++;
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL frame_unexpected: got %h, required no frame", frame_data);
            end else begin
               sb_exp = sb.pop_front();
               if (frame_data !== sb_exp) begin
                  miscompares++;
                  $display("FAIL frame_data: got %h, required %h", frame_data, sb_exp);
               end else begin
                  $display("frame %h accepted at cycle %0d", frame_data, cyc);
               end
            end
            @(posedge ACLK);
            repeat (DONE_DLY) @(negedge ACLK);
            #1 frame_done = 1'b1;
            done_cyc = cyc;
            @(negedge ACLK);
            #1 frame_done = 1'b0;
            shifter_busy = 1'b0;
         end
      end
   end

   // LDAC monitor: records fall cycle and checks every pulse width.
   initial begin : ldac_mon
      forever begin
         @(negedge ACLK);
         if (ldac_n === 1'b0) begin
            if (ldac_prev === 1'b1) begin
               ldac_fall_cyc = cyc;
               ldac_width    = 0;
            end
            ldac_width++;
         end else if (ldac_n === 1'b1 && ldac_prev === 1'b0) begin
            ldac_pulses++;
            vectors++;
            if (ldac_width != LDAC_PULSE) begin
               miscompares++;
               $display("FAIL ldac_width: got %0d, required %0d", ldac_width, LDAC_PULSE);
            end else begin
               $display("ldac pulse %0d cycles, fell at cycle %0d", ldac_width, ldac_fall_cyc);
            end
         end
         ldac_prev = ldac_n;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Drive one write for a single cycle; called at a falling edge, returns at the next.
   task automatic do_write(input int ch, input logic [DATA_W-1:0] data);
      wr_valid = 1'b1;
      wr_ch    = 3'(ch);
      wr_data  = data;
      $display("write ch=%0d data=%h at cycle %0d", ch, data, cyc);
      @(negedge ACLK);
      wr_valid = 1'b0;
   endtask

   task automatic wait_quiet(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge ACLK);
         if (busy === 1'b0 && !shifter_busy && sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      @(negedge ACLK);
   endtask

   task automatic wait_fv(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge ACLK);
         if (frame_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      ARESETN = 1'b0;
      repeat (3) @(negedge ACLK);
      vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL rst_wr_ready: got %b, required 0", wr_ready); end
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL rst_frame_valid: got %b, required 0", frame_valid); end
      vectors++; if (frame_data !== 24'h0) begin miscompares++; $display("FAIL rst_frame_data: got %h, required 000000", frame_data); end
      vectors++; if (ldac_n !== 1'b1) begin miscompares++; $display("FAIL rst_ldac_n: got %b, required 1", ldac_n); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, required 0", busy); end
      vectors++; if (trig_late !== 1'b0) begin miscompares++; $display("FAIL rst_trig_late: got %b, required 0", trig_late); end
      ARESETN = 1'b1;
      @(negedge ACLK);
      vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL wr_ready_after_rst: got %b, required 1", wr_ready); end
      $display("reset checked");
   endtask

   task automatic test_single_write;
      int p0;
      bit ok;
      mode = 1'b0;
      frame_ready = 1'b1;
      p0 = ldac_pulses;
      sb.push_back(24'h02ABC0);
      do_write(2, 12'hABC);
      @(negedge ACLK);
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL fv_at_n2: got %b, required 0", frame_valid); end
      @(negedge ACLK);
      vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL fv_at_n3: got %b, required 1", frame_valid); end
      vectors++; if (frame_data !== 24'h02ABC0) begin miscompares++; $display("FAIL fd_at_n3: got %h, required 02abc0", frame_data); end
      wait_quiet(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL single_timeout: got busy=%b, required idle", busy); end
      vectors++; if (ldac_pulses !== p0 + 1) begin miscompares++; $display("FAIL single_ldac_count: got %0d, required %0d", ldac_pulses - p0, 1); end
      vectors++; if (ldac_fall_cyc !== done_cyc + 1) begin miscompares++; $display("FAIL single_ldac_latency: got %0d, required %0d", ldac_fall_cyc, done_cyc + 1); end
   endtask

   task automatic test_round_robin;
      int p0, h0;
      bit ok;
      p0 = ldac_pulses;
      h0 = hs_count;
      sb.push_back(24'h055550);
      do_write(5, 12'h555);
      repeat (4) @(negedge ACLK);
      // ch5 is in flight and rr_ptr now points at 6; queue the next three in reverse order.
      sb.push_back(24'h066060);
      sb.push_back(24'h077070);
      sb.push_back(24'h011010);
      do_write(1, 12'h101);
      do_write(7, 12'h707);
      do_write(6, 12'h606);
      wait_quiet(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rr_timeout: got busy=%b, required idle", busy); end
      vectors++; if (hs_count !== h0 + 4) begin miscompares++; $display("FAIL rr_frames: got %0d, required 4", hs_count - h0); end
      vectors++; if (ldac_pulses !== p0 + 1) begin miscompares++; $display("FAIL rr_ldac_count: got %0d, required 1", ldac_pulses - p0); end
   endtask

   task automatic test_coalesce;
      int p0, h0;
      bit ok;
      p0 = ldac_pulses;
      h0 = hs_count;
      sb.push_back(24'h032220);
      do_write(3, 12'h111);
      do_write(3, 12'h222);
      wait_quiet(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL coal_timeout: got busy=%b, required idle", busy); end
      vectors++; if (hs_count !== h0 + 1) begin miscompares++; $display("FAIL coal_frames: got %0d, required 1", hs_count - h0); end
      vectors++; if (ldac_pulses !== p0 + 1) begin miscompares++; $display("FAIL coal_ldac_count: got %0d, required 1", ldac_pulses - p0); end
   endtask

   task automatic test_back_to_back;
      int p0, h0;
      bit ok;
      p0 = ldac_pulses;
      h0 = hs_count;
      sb.push_back(24'h033330);
      sb.push_back(24'h034440);
      do_write(3, 12'h333);
      @(negedge ACLK);
      // This write lands in the same cycle the sequencer scans ch3.
      do_write(3, 12'h444);
      wait_quiet(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL race_timeout: got busy=%b, required idle", busy); end
      vectors++; if (hs_count !== h0 + 2) begin miscompares++; $display("FAIL race_frames: got %0d, required 2", hs_count - h0); end
      vectors++; if (ldac_pulses !== p0 + 1) begin miscompares++; $display("FAIL race_ldac_count: got %0d, required 1", ldac_pulses - p0); end
   endtask

   task automatic test_trigger_mode;
      int p0;
      bit ok;
      mode = 1'b1;
      p0 = ldac_pulses;
      sb.push_back(24'h000F00);
      do_write(0, 12'h0F0);
      repeat (20) @(negedge ACLK);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL trig_wait_busy: got %b, required 1", busy); end
      vectors++; if (ldac_n !== 1'b1) begin miscompares++; $display("FAIL trig_wait_ldac: got %b, required 1", ldac_n); end
      vectors++; if (ldac_pulses !== p0) begin miscompares++; $display("FAIL trig_wait_pulses: got %0d, required 0", ldac_pulses - p0); end
      trigger = 1'b1;
      @(negedge ACLK);
      trigger = 1'b0;
      vectors++; if (ldac_n !== 1'b0) begin miscompares++; $display("FAIL trig_ldac_next: got %b, required 0", ldac_n); end
      wait_quiet(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL trig_timeout: got busy=%b, required idle", busy); end
      vectors++; if (ldac_pulses !== p0 + 1) begin miscompares++; $display("FAIL trig_ldac_count: got %0d, required 1", ldac_pulses - p0); end
      vectors++; if (trig_late !== 1'b0) begin miscompares++; $display("FAIL trig_not_late: got %b, required 0", trig_late); end
   endtask

   task automatic test_trig_late;
      int p0;
      bit ok;
      mode = 1'b1;
      frame_ready = 1'b0;
      p0 = ldac_pulses;
      sb.push_back(24'h015A50);
      do_write(1, 12'h5A5);
      wait_fv(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL late_fv_timeout: got %b, required 1", frame_valid); end
      trigger = 1'b1;
      @(negedge ACLK);
      trigger = 1'b0;
      vectors++; if (trig_late !== 1'b1) begin miscompares++; $display("FAIL late_set: got %b, required 1", trig_late); end
      @(negedge ACLK);
      vectors++; if (frame_data !== 24'h015A50) begin miscompares++; $display("FAIL late_fd_hold: got %h, required 015a50", frame_data); end
      vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL late_fv_hold: got %b, required 1", frame_valid); end
      frame_ready = 1'b1;
      wait_quiet(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL late_timeout: got busy=%b, required idle", busy); end
      vectors++; if (ldac_pulses !== p0 + 1) begin miscompares++; $display("FAIL late_ldac_count: got %0d, required 1", ldac_pulses - p0); end
      vectors++; if (ldac_fall_cyc !== done_cyc + 1) begin miscompares++; $display("FAIL late_ldac_latency: got %0d, required %0d", ldac_fall_cyc, done_cyc + 1); end
      vectors++; if (trig_late !== 1'b1) begin miscompares++; $display("FAIL late_sticky: got %b, required 1", trig_late); end
      clr_flags = 1'b1;
      @(negedge ACLK);
      clr_flags = 1'b0;
      vectors++; if (trig_late !== 1'b0) begin miscompares++; $display("FAIL late_clear: got %b, required 0", trig_late); end
   endtask

   task automatic test_mode0_trigger;
      mode = 1'b0;
      trigger = 1'b1;
      @(negedge ACLK);
      trigger = 1'b0;
      @(negedge ACLK);
      vectors++; if (trig_late !== 1'b0) begin miscompares++; $display("FAIL m0_trig_late: got %b, required 0", trig_late); end
      vectors++; if (ldac_n !== 1'b1) begin miscompares++; $display("FAIL m0_ldac: got %b, required 1", ldac_n); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL m0_busy: got %b, required 0", busy); end
      $display("mode0 trigger ignored check done");
   endtask

   task automatic test_reset_mid_send;
      int p0, h0;
      bit ok;
      mode = 1'b0;
      frame_ready = 1'b0;
      p0 = ldac_pulses;
      h0 = hs_count;
      do_write(4, 12'h444);
      do_write(5, 12'h555);
      wait_fv(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rms_fv_timeout: got %b, required 1", frame_valid); end
      ARESETN = 1'b0;
      @(negedge ACLK);
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL rms_fv_drop: got %b, required 0", frame_valid); end
      vectors++; if (frame_data !== 24'h0) begin miscompares++; $display("FAIL rms_fd: got %h, required 000000", frame_data); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rms_busy: got %b, required 0", busy); end
      @(negedge ACLK);
      frame_ready = 1'b1;
      ARESETN = 1'b1;
      repeat (20) @(negedge ACLK);
      vectors++; if (hs_count !== h0) begin miscompares++; $display("FAIL rms_frames: got %0d, required 0", hs_count - h0); end
      vectors++; if (ldac_pulses !== p0) begin miscompares++; $display("FAIL rms_ldac: got %0d, required 0", ldac_pulses - p0); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rms_idle: got %b, required 0", busy); end
      vectors++; if (ldac_n !== 1'b1) begin miscompares++; $display("FAIL rms_ldac_n: got %b, required 1", ldac_n); end
   endtask

   initial begin
      @(negedge ACLK);
      test_reset();
      test_single_write();
      test_round_robin();
      test_coalesce();
      test_back_to_back();
      test_trigger_mode();
      test_trig_late();
      test_mode0_trigger();
      test_reset_mid_send();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/amdc_dac_sequencer.md
Name: amdc_dac_sequencer

Overview:
Schedules channel updates for the AMDC SPI DAC. Per-channel values written from the AXI-lite register file are held in shadow registers and marked dirty. Dirty channels are serialised round-robin into 24-bit frames for the SPI shifter. The block then asserts LDAC either immediately or aligned to a PWM carrier trigger, so all channels update together.

Parameters:
NUM_CH, 8, number of DAC channels (power of two, 2..16)
DATA_W, 12, DAC code width
FRAME_W, 24, SPI frame width
LDAC_PULSE, 4, LDAC low time in ACLK cycles (>=1)

Ports:
ACLK  in  1  clock
ARESETN  in  1  synchronous active-low reset
wr_valid  in  1  channel write request
wr_ready  out  1  always 1 outside reset
wr_ch  in  $clog2(NUM_CH)  target channel
wr_data  in  DATA_W  DAC code
mode  in  1  0 = LDAC after each batch; 1 = LDAC on trigger
trigger  in  1  single-cycle PWM carrier sync pulse
frame_valid  out  1  frame offered to SPI shifter
frame_ready  in  1  shifter accepts frame
frame_data  out  FRAME_W  {4'b0000, 4'(ch), data, zero-pad} (MSB first)
frame_done  in  1  shifter finished shifting the accepted frame
ldac_n  out  1  active-low DAC load strobe
busy  out  1  high in any state other than IDLE
trig_late  out  1  sticky; a trigger arrived while a batch was in flight
clr_flags  in  1  clears trig_late

Behaviour:
- Reset values: wr_ready=0, frame_valid=0, frame_data=0, ldac_n=1, busy=0, trig_late=0.
- Reset also clears all shadow registers, dirty bits, the round-robin pointer, pend_trig and sent flag.
- Reset mid-frame drops frame_valid in the same cycle. The shifter shares ARESETN.
- Write accepted on wr_valid&wr_ready:
  - shadow[wr_ch] <= wr_data; dirty[wr_ch] <= 1 on the next edge.
  - A rewrite of a dirty channel coalesces: last value wins, one frame is sent.
- FSM states: IDLE, SCAN, SEND, WAIT_DONE, WAIT_TRIG, LDAC.
- IDLE: if any dirty bit -> SCAN.
- SCAN (1 cycle):
  - Pick the first dirty index at or after rr_ptr, wrapping modulo NUM_CH.
  - Register frame_data from shadow.
  - Clear that dirty bit, unless a write to the same channel occurs that cycle (the write wins and dirty stays 1).
  - rr_ptr <= idx+1 (wraps). -> SEND.
- SEND: frame_valid=1 and frame_data held stable until frame_ready. On the handshake, deassert frame_valid, set sent=1 -> WAIT_DONE.
- WAIT_DONE: on frame_done:
  - any dirty -> SCAN;
  - else mode=0 -> LDAC;
  - else pend_trig -> LDAC;
  - else -> WAIT_TRIG.
- WAIT_TRIG: new dirty -> SCAN (takes priority over a same-cycle trigger; that trigger is pended). Trigger with nothing dirty -> LDAC.
- Trigger handling:
  - Trigger in SCAN/SEND/WAIT_DONE with mode=1 sets pend_trig and trig_late.
  - Trigger in IDLE (sent=0) is ignored.
  - With mode=0, trigger is ignored in every state.
- LDAC: ldac_n=0 for exactly LDAC_PULSE cycles. On exit, clear pend_trig and sent -> IDLE. Writes are still accepted during LDAC.
- Latency, write to first frame: write in cycle N, dirty in N+1 (IDLE sees it), SCAN in N+2, frame_valid in N+3.
- Latency, last frame_done to strobe (mode=0): ldac_n falls on the cycle after frame_done.
- mode is sampled only at the WAIT_DONE exit decision. Changing mode mid-batch is legal.
- clr_flags has priority over a same-cycle trig_late set.

Decomposition:
- Package amdc_dac_pkg holds:
  - state_t enum;
  - FRAME_CMD_WRITE = 4'b0000;
  - frame-field offset constants;
  - a function build_frame(ch, data).
- One sub-module, amdc_dac_rr_pick: combinational round-robin first-set finder over the dirty vector given rr_ptr. Outputs idx and found.

Test Plan:
- Single write, mode=0: write ch2=0xABC with frame_ready=1 and frame_done 10 cycles after accept -> frame_data=24'h02ABC0 at N+3; ldac_n low 4 cycles starting the cycle after frame_done.
- Round-robin wrap: rr_ptr=6, then ch1, ch7, ch6 written in the same batch -> frames sent in order ch6, ch7, ch1 followed by one LDAC pulse.
- Coalesce: write ch3=0x111, then ch3=0x222 before SCAN -> exactly one frame 24'h032220.
- Same-channel race: write ch3 during the SCAN that picks ch3 -> ch3 is sent twice, second frame carries the new value, one LDAC.
- Trigger mode: mode=1, write ch0 with no trigger -> WAIT_TRIG and ldac_n=1; trigger -> LDAC on the next cycle.
  - Trigger during SEND -> trig_late=1 and LDAC directly after frame_done.
  - clr_flags -> trig_late=0.
- Reset mid-SEND with frame_ready=0: deassert ARESETN -> frame_valid=0 next edge; dirty cleared; no LDAC after release.
